// File: rtl/alu_pkg.sv
// Shared defaults, opcode constants and the sequencer state encoding for the
// ALU command sequencer and its command buffer.
package alu_pkg;

    localparam int DEF_DATA_W = 9;
    localparam int DEF_OP_W   = 4;
    localparam int DEF_DEPTH  = 4;

    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_NOT   = 4'b0101;
    localparam logic [3:0] OP_UNDEF = 4'b0110;
    localparam logic [3:0] OP_ADD   = 4'b0111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command buffer: DEPTH-entry FIFO with registered occupancy count.
// Pointers wrap naturally because DEPTH is a power of two.
module alu_cmd_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    // Guards keep the buffer consistent even if a caller misbehaves.
    assign do_push = push_i && (count_q < CW'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, issues them one at a time to an external combinational
// ALU and holds each result until the consumer accepts it.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int OP_W   = DEF_OP_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_opcode,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [OP_W-1:0]   alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [OP_W-1:0]   res_opcode,
    output logic              res_err,
    output logic              busy,
    output state_t            dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; in_ready depends only on registered state, and res_* stay
    // frozen while res_valid && !res_ready.

    localparam int EW = OP_W + 2 * DATA_W;
    localparam int CW = $clog2(DEPTH) + 1;

    state_t            state_q;
    logic [OP_W-1:0]   alu_opcode_q;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic              res_valid_q;
    logic [DATA_W-1:0] res_data_q;
    logic [OP_W-1:0]   res_opcode_q;
    logic              res_err_q;

    logic [CW-1:0]     count;
    logic [EW-1:0]     head;
    logic              push;
    logic              pop;

    assign in_ready = (count < CW'(DEPTH));
    assign push     = in_valid && in_ready;

    always_comb begin
        pop = 1'b0;
        case (state_q)
            S_IDLE:  pop = (count != '0);
            S_HOLD:  pop = res_ready && (count != '0);
            default: pop = 1'b0;
        endcase
    end

    alu_cmd_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i ({in_opcode, in_a, in_b}),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            alu_opcode_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_opcode_q <= '0;
            res_err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        {alu_opcode_q, alu_a_q, alu_b_q} <= head;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    res_valid_q  <= 1'b1;
                    res_opcode_q <= alu_opcode_q;
                    if (alu_opcode_q == OP_W'(OP_UNDEF)) begin
                        res_data_q <= '0;
                        res_err_q  <= 1'b1;
                    end else begin
                        res_data_q <= alu_out;
                        res_err_q  <= 1'b0;
                    end
                    state_q <= S_HOLD;
                end
                S_HOLD: begin
                    // The held result is consumed on this edge, so valid drops
                    // during the next EXEC and each result is seen exactly once.
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        if (pop) begin
                            {alu_opcode_q, alu_a_q, alu_b_q} <= head;
                            state_q <= S_EXEC;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign alu_opcode = alu_opcode_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_opcode = res_opcode_q;
    assign res_err    = res_err_q;
    assign busy       = (state_q != S_IDLE) || (count != '0);
    assign dbg_state  = state_q;

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter DATA_W, default 9, operand and result width.
REQ-002 Parameter OP_W, default 4, opcode width.
REQ-003 Parameter DEPTH, default 4, command buffer entries (power of two).
REQ-004 The block SHALL use one clock, and its reset SHALL be synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 in_valid  in  1  command offered.
REQ-008 in_ready  out  1  command buffer can accept.
REQ-009 in_opcode  in  OP_W  ALU opcode.
REQ-010 in_a / in_b  in  DATA_W  operands A and B.
REQ-011 alu_opcode  out  OP_W  registered opcode driven to the ALU.
REQ-012 alu_a / alu_b  out  DATA_W  registered operands driven to the ALU.
REQ-013 alu_out  in  DATA_W  combinational ALU result.
REQ-014 res_valid  out  1  result held.
REQ-015 res_ready  in  1  consumer accepts result.
REQ-016 res_data  out  DATA_W  captured result.
REQ-017 res_opcode  out  OP_W  opcode that produced res_data.
REQ-018 res_err  out  1  result came from an unimplemented opcode.
REQ-019 busy  out  1  high when state is not IDLE or the buffer is non-empty.

Function
REQ-020 A command SHALL be pushed on any edge where in_valid && in_ready; in_ready = (count < DEPTH), derived from registered count only.
REQ-021 The buffer SHALL be FIFO-ordered; a push when full SHALL NOT occur, and a same-cycle pop SHALL NOT make a full buffer accept.
REQ-022 FSM states: IDLE, EXEC, HOLD.
REQ-023 IDLE: if count>0, pop head into alu_* registers -> EXEC; otherwise stay.
REQ-024 EXEC: capture alu_out into res_data, alu_opcode into res_opcode, set res_valid=1 -> HOLD.
REQ-025 HOLD on res_ready=1: if count>0, pop into alu_* -> EXEC; otherwise clear res_valid -> IDLE.
REQ-026 HOLD on res_ready=0: all res_* outputs SHALL hold stable.
REQ-027 Latency: res_valid SHALL rise 2 edges after the accepting edge when starting from IDLE with an empty buffer; sustained throughput is 1 result per 2 cycles.
REQ-028 Opcode 4'b0110 (unimplemented in the ALU): in EXEC, res_data SHALL be 0 and res_err SHALL be 1; for all other opcodes res_err SHALL be 0 and res_data = alu_out.
REQ-029 Simultaneous push and pop SHALL update count by net 0; pointers SHALL wrap modulo DEPTH.
REQ-030 A push into an empty buffer in IDLE SHALL NOT be popped on the same edge.

Reset
REQ-031 On rst: state=IDLE, count=0, pointers=0, res_valid=0, res_err=0, res_data=0, res_opcode=0, alu_a=alu_b=0, alu_opcode=0.
REQ-032 Reset mid-operation SHALL discard all buffered commands and any held result, with no partial output on the next cycle.

Structure
REQ-033 Package alu_pkg SHALL hold DATA_W, OP_W, DEPTH defaults, opcode constants (including OP_UNDEF=4'b0110), and the FSM state enum.
REQ-034 The command buffer SHALL be a sub-module alu_cmd_fifo (push/pop/count/head) instantiated once.

Verification
REQ-035 Accept op=0111, A=9'h005, B=9'h003 from IDLE -> res_valid=1 two edges later, res_data=9'h008, res_err=0.
REQ-036 With res_ready=0, offer commands every cycle -> exactly 5 accepted (1 held + 4 buffered), then in_ready=0.
REQ-037 Release res_ready=1 after REQ-036 -> 5 results in push order at 1 per 2 cycles, then IDLE and busy=0.
REQ-038 Accept op=0110, A=9'h0FF -> res_data=0, res_err=1, res_opcode=4'b0110.
REQ-039 Assert rst while in HOLD with 3 commands buffered -> next cycle res_valid=0, in_ready=1, busy=0, and no stale results after release.
REQ-040 Full buffer, in_valid=1 during a same-cycle pop -> no push on that edge, and the push occurs on the following edge.
